// File: rtl/rand_backoff_pkg.sv
// Shared types and constants for the randomised retry-backoff timer.
package rand_backoff_pkg;

    localparam int RND_W = 3;
    localparam int ATT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The slot count is the random value shifted by up to max_exp places.
    function automatic int slot_width(input int max_exp);
        return RND_W + max_exp;
    endfunction

endpackage

// File: rtl/rand_backoff_if.sv
// Requester-side handshake of the backoff timer; abort_cnt exists only with RAND_BACKOFF_STATS_EN.
interface rand_backoff_if;
    import rand_backoff_pkg::*;

    logic [RND_W-1:0] rnd;
    logic             start;
    logic             success;
    logic             busy;
    logic             go;
    logic             abort;
    logic [ATT_W-1:0] attempt;
`ifdef RAND_BACKOFF_STATS_EN
    logic [7:0]       abort_cnt;
`endif

    modport slave (
        input  rnd,
        input  start,
        input  success,
        output busy,
        output go,
        output abort,
`ifdef RAND_BACKOFF_STATS_EN
        output abort_cnt,
`endif
        output attempt
    );

    modport master (
        output rnd,
        output start,
        output success,
        input  busy,
        input  go,
        input  abort,
`ifdef RAND_BACKOFF_STATS_EN
        input  abort_cnt,
`endif
        input  attempt
    );

endinterface

// File: rtl/rand_backoff_slot_timer.sv
// Loadable slot x cycle-in-slot down-counter; done marks the final cycle of the wait.
module backoff_slot_timer #(
    parameter int SLOT_W   = 6,
    parameter int SLOT_CYC = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic [SLOT_W-1:0] slots,
    input  logic              count,
    input  logic              cancel,
    output logic              done
);

    localparam int CYC_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYC - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [CYC_W-1:0]  cyc_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            slot_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (cancel) begin
            slot_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (load) begin
            slot_cnt <= slots;
            cyc_cnt  <= CYC_LAST;
        end else if (count && (slot_cnt != '0)) begin
            if (cyc_cnt == '0) begin
                slot_cnt <= slot_cnt - SLOT_W'(1);
                cyc_cnt  <= CYC_LAST;
            end else begin
                cyc_cnt  <= cyc_cnt - CYC_W'(1);
            end
        end
    end

    // Last slot with its last cycle: the wait ends after this clock.
    assign done = count && (slot_cnt == SLOT_W'(1)) && (cyc_cnt == '0);

endmodule

// File: rtl/rand_backoff.sv
// Randomised exponential retry-backoff timer; RAND_BACKOFF_STATS_EN adds a saturating abort_cnt output.
module rand_backoff
    import rand_backoff_pkg::*;
#(
    parameter int SLOT_CYC = 4,
    parameter int MAX_EXP  = 3,
    parameter int MAX_ATT  = 8
) (
    input  logic           clk,
    input  logic           clrn,
    rand_backoff_if.slave  bus
);

    localparam int SLOT_W = slot_width(MAX_EXP);
    localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_ATT);
    localparam logic [ATT_W-1:0] EXP_MAX = ATT_W'(MAX_EXP);

    state_t            state;
    state_t            state_nxt;
    logic [ATT_W-1:0]  attempt_q;
    logic [ATT_W-1:0]  att_nxt;
    logic [ATT_W-1:0]  att_base;
    logic [ATT_W-1:0]  exp_sel;
    logic [SLOT_W-1:0] slots;
    logic              go_q;
    logic              go_nxt;
    logic              abort_q;
    logic              abort_nxt;
    logic              accept;
    logic              at_limit;
    logic              zero_win;
    logic              load;
    logic              count;
    logic              cancel;
    logic              done;

    // Success in the same cycle as start is applied first.
    assign att_base = bus.success ? '0 : attempt_q;
    assign exp_sel  = (att_base > EXP_MAX) ? EXP_MAX : att_base;
    assign slots    = SLOT_W'(bus.rnd) << exp_sel;
    assign accept   = (state == IDLE) && bus.start;
    assign at_limit = (att_base == ATT_MAX);
    assign zero_win = (bus.rnd == '0);

    backoff_slot_timer #(
        .SLOT_W   (SLOT_W),
        .SLOT_CYC (SLOT_CYC)
    ) u_timer (
        .clk    (clk),
        .clrn   (clrn),
        .load   (load),
        .slots  (slots),
        .count  (count),
        .cancel (cancel),
        .done   (done)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            attempt_q <= '0;
            go_q      <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            attempt_q <= att_nxt;
            go_q      <= go_nxt;
            abort_q   <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !at_limit && !zero_win) state_nxt = WAIT;
            WAIT: if (bus.success || done)              state_nxt = IDLE;
            default:                                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        go_nxt    = 1'b0;
        abort_nxt = 1'b0;
        att_nxt   = attempt_q;
        load      = 1'b0;
        count     = 1'b0;
        cancel    = 1'b0;
        case (state)
            IDLE: begin
                att_nxt = att_base;
                if (accept) begin
                    if (at_limit) begin
                        abort_nxt = 1'b1;
                    end else begin
                        att_nxt = att_base + ATT_W'(1);
                        if (zero_win) go_nxt = 1'b1;
                        else          load   = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A success on the final wait cycle still cancels: no go.
                count = 1'b1;
                if (bus.success) begin
                    cancel  = 1'b1;
                    att_nxt = '0;
                end else if (done) begin
                    go_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state == WAIT);
    assign bus.go      = go_q;
    assign bus.abort   = abort_q;
    assign bus.attempt = attempt_q;

`ifdef RAND_BACKOFF_STATS_EN
    logic [7:0] abort_cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                              abort_cnt_q <= '0;
        else if (abort_nxt && (abort_cnt_q != 8'hFF)) abort_cnt_q <= abort_cnt_q + 8'd1;
    end

    assign bus.abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_rand_backoff.sv
// Scoreboard bench for rand_backoff: a cycle-stamped event model predicts every go/abort pulse.
module tb_rand_backoff;
    import rand_backoff_pkg::*;

    localparam int SLOT_CYC = 4;
    localparam int MAX_EXP  = 3;
    localparam int MAX_ATT  = 8;

    typedef struct {
        bit is_abort;
        int cyc;
    } ev_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    rand_backoff_if bus();

    rand_backoff #(
        .SLOT_CYC (SLOT_CYC),
        .MAX_EXP  (MAX_EXP),
        .MAX_ATT  (MAX_ATT)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    ev_t exp_q[$];
    ev_t mon_ev;
    int  cyc      = 0;
    int  n_vec    = 0;
    int  n_err    = 0;
    int  m_att    = 0;
    int  m_go_cyc = 0;
    int  m_aborts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Reference: a retry started at cycle c ends with go at c+1+W, or abort at c+1.
    task automatic model_step(input bit s, input int r, input bit suc);
        int c;
        int w;
        int e;
        c = cyc;
        if (c < m_go_cyc) begin
            if (suc) begin
                void'(exp_q.pop_back());
                m_go_cyc = c + 1;
                m_att    = 0;
            end
        end else begin
            if (suc) m_att = 0;
            if (s) begin
                if (m_att == MAX_ATT) begin
                    exp_q.push_back('{1'b1, c + 1});
                    m_aborts++;
                end else begin
                    e = (m_att < MAX_EXP) ? m_att : MAX_EXP;
                    w = r * (1 << e) * SLOT_CYC;
                    exp_q.push_back('{1'b0, c + 1 + w});
                    m_go_cyc = c + 1 + w;
                    m_att++;
                end
            end
        end
    endtask

    task automatic drive(input bit s, input int r, input bit suc);
        @(negedge clk);
        bus.start   = s;
        bus.rnd     = 3'(r);
        bus.success = suc;
        model_step(s, r & 7, suc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((cyc + 1 < m_go_cyc) && (guard < 2000)) begin
            drive(1'b0, int'($urandom_range(0, 7)), 1'b0);
            guard++;
        end
        check("wait_idle_bound", guard, (guard < 2000) ? guard : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn        = 1'b0;
        bus.start   = 1'b0;
        bus.success = 1'b0;
        exp_q.delete();
        m_att    = 0;
        m_go_cyc = 0;
        m_aborts = 0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_go", bus.go, 0);
        check("reset_abort", bus.abort, 0);
        check("reset_attempt", bus.attempt, 0);
        idle(2);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // Monitor: level checks every cycle, event checks against the queue head.
    always @(posedge clk) begin
        #1;
        check("busy", bus.busy, cyc < m_go_cyc);
        check("attempt", bus.attempt, m_att);
        check("go_abort_excl", bus.go & bus.abort, 0);
        if (bus.go || bus.abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", bus.go | bus.abort, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                check("event_is_abort", bus.abort, mon_ev.is_abort);
                check("event_cycle", cyc, mon_ev.cyc);
            end
        end else if ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc)) begin
            mon_ev = exp_q.pop_front();
            check("missing_event", bus.go | bus.abort, 1);
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.rnd     = '0;
        bus.success = 1'b0;
        repeat (3) @(negedge clk);
        check("por_attempt", bus.attempt, 0);
        check("por_busy", bus.busy, 0);
        clrn = 1'b1;

        // rnd=3 from attempt 0: 12-cycle wait
        drive(1'b1, 3, 1'b0);
        wait_idle();
        drive(1'b0, 0, 1'b1);

        // zero window: immediate go
        drive(1'b1, 0, 1'b0);
        wait_idle();
        drive(1'b0, 0, 1'b1);

        // growing window 20, 40, 80, 160, 160
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            drive(1'b1, 5, 1'b0);
        end
        wait_idle();
        drive(1'b0, 0, 1'b1);

        // cancel mid-wait; a start while busy is ignored
        drive(1'b1, 7, 1'b0);
        idle(4);
        drive(1'b1, 2, 1'b0);
        idle(4);
        drive(1'b0, 0, 1'b1);
        wait_idle();

        // exhaust attempts, then abort twice; success+start restarts at attempt 0
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < MAX_ATT; i++) begin
            wait_idle();
            drive(1'b1, i % 2, 1'b0);
        end
        wait_idle();
        drive(1'b1, 6, 1'b0);
        drive(1'b1, 6, 1'b0);
        idle(1);
`ifdef RAND_BACKOFF_STATS_EN
        check("abort_cnt_mid", bus.abort_cnt, m_aborts);
`endif
        drive(1'b1, 1, 1'b1);
        wait_idle();

        // success in the go cycle clears attempt but go still fires
        drive(1'b1, 2, 1'b0);
        wait_idle();
        drive(1'b0, 0, 1'b1);
        idle(2);

        // reset mid-wait discards the pending go
        drive(1'b1, 7, 1'b0);
        idle(5);
        do_reset();
        drive(1'b1, 1, 1'b0);
        wait_idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0);
        end
        wait_idle();
        idle(3);
        check("queue_drained", exp_q.size(), 0);
`ifdef RAND_BACKOFF_STATS_EN
        check("abort_cnt_end", bus.abort_cnt, (m_aborts > 255) ? 255 : m_aborts);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
